// File: rtl/opr_seq_resp.sv
// Responder for the operation-pulse interface: launches the controller with
// `valid`, tracks the opr_1..opr_5 phase stream and finishes on halt or limit.
module opr_seq_resp #(
  parameter int MAX_INSTR = 400,
  parameter int AW        = 10
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic          instr_is_halt,
  input  logic          opr_1,
  input  logic          opr_2,
  input  logic          opr_3,
  input  logic          opr_4,
  input  logic          opr_5,
  output logic          valid,
  output logic          opr_finished,
  output logic          busy,
  output logic [AW-1:0] instr_addr,
  output logic [8:0]    instr_cnt,
  output logic          halted,
  output logic          seq_err
);

  localparam logic [8:0] CNT_LAST = 9'(MAX_INSTR - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, ERR} state_t;

  state_t     state;
  logic [2:0] exp_ph;
  logic [2:0] obs_ph;
  logic       code_ok;
  logic       ph_ok;
  logic       end_flag;

  // Only thermometer codes map to a phase; everything else is a protocol fault.
  always_comb begin
    obs_ph  = 3'd0;
    code_ok = 1'b1;
    case ({opr_5, opr_4, opr_3, opr_2, opr_1})
      5'b00001: obs_ph = 3'd0;
      5'b00011: obs_ph = 3'd1;
      5'b00111: obs_ph = 3'd2;
      5'b01111: obs_ph = 3'd3;
      5'b11111: obs_ph = 3'd4;
      default:  code_ok = 1'b0;
    endcase
  end

  assign ph_ok = code_ok && (obs_ph == exp_ph);

  always_ff @(posedge clk) begin
    if (rstb) begin
      state        <= IDLE;
      exp_ph       <= 3'd0;
      end_flag     <= 1'b0;
      valid        <= 1'b0;
      opr_finished <= 1'b0;
      busy         <= 1'b0;
      instr_addr   <= '0;
      instr_cnt    <= 9'd0;
      halted       <= 1'b0;
      seq_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LAUNCH;
            valid      <= 1'b1;
            busy       <= 1'b1;
            instr_addr <= start_addr;
            instr_cnt  <= 9'd0;
            halted     <= 1'b0;
            end_flag   <= 1'b0;
            exp_ph     <= 3'd0;
          end
        end
        LAUNCH: begin
          valid <= 1'b0;
          if (!ph_ok) begin
            state   <= ERR;
            seq_err <= 1'b1;
            busy    <= 1'b0;
          end else begin
            state  <= RUN;
            exp_ph <= 3'd1;
          end
        end
        RUN: begin
          if (!ph_ok) begin
            state        <= ERR;
            seq_err      <= 1'b1;
            busy         <= 1'b0;
            opr_finished <= 1'b0;
          end else begin
            exp_ph <= (exp_ph == 3'd4) ? 3'd0 : exp_ph + 3'd1;
            case (exp_ph)
              3'd1: end_flag <= instr_is_halt;
              3'd3: begin
                if (end_flag || instr_cnt == CNT_LAST) begin
                  opr_finished <= 1'b1;
                  halted       <= end_flag;
                end
              end
              3'd4: begin
                instr_cnt <= instr_cnt + 9'd1;
                // opr_finished doubles as the "this is the final instruction" flag
                if (opr_finished) begin
                  opr_finished <= 1'b0;
                  busy         <= 1'b0;
                  state        <= IDLE;
                end else begin
                  instr_addr <= instr_addr + AW'(1);
                end
              end
              default: ;
            endcase
          end
        end
        ERR: ;
        default: state <= ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_opr_seq_resp.sv
// Bench for opr_seq_resp: a cycle-indexed controller model drives the phase
// lines; expected run results come from instruction-count arithmetic.
module tb_opr_seq_resp;
  localparam int MAX = 400;
  localparam int AW  = 10;

  logic          clk = 1'b0;
  logic          rstb = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          instr_is_halt = 1'b0;
  logic [4:0]    lines = 5'b00001;
  logic          valid, opr_finished, busy, halted, seq_err;
  logic [AW-1:0] instr_addr;
  logic [8:0]    instr_cnt;

  int npass = 0;
  int ntot  = 0;
  int o_v0, o_fin_t, o_err_t, o_nfin, o_nvalid, o_nbusy, o_busy_err;

  opr_seq_resp #(.MAX_INSTR(MAX), .AW(AW)) dut (
    .clk(clk), .rstb(rstb), .start(start), .start_addr(start_addr),
    .instr_is_halt(instr_is_halt),
    .opr_1(lines[0]), .opr_2(lines[1]), .opr_3(lines[2]), .opr_4(lines[3]), .opr_5(lines[4]),
    .valid(valid), .opr_finished(opr_finished), .busy(busy), .instr_addr(instr_addr),
    .instr_cnt(instr_cnt), .halted(halted), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] code(input int ph);
    return 5'((32'd1 << (ph + 1)) - 1);
  endfunction

  task automatic do_reset();
    rstb = 1'b1; start = 1'b0; instr_is_halt = 1'b0; lines = code(0);
    repeat (2) @(posedge clk);
    #1 rstb = 1'b0;
  endtask

  // Controller model: t counts cycles from the valid cycle, phase = t mod 5,
  // instruction index = ceil(t/5). Records what the DUT shows each cycle.
  task automatic drive(input logic [AW-1:0] sa, input int halt_idx, input bit noise,
                       input int inj_t, input logic [4:0] inj_code, input int xstart_t,
                       input int max_t);
    int t, ph, idx;
    t = 0;
    o_fin_t = -1; o_err_t = -1; o_nfin = 0; o_nvalid = 0; o_nbusy = 0; o_busy_err = -1;
    start_addr = sa; start = 1'b1; lines = code(0);
    @(posedge clk); #1;
    start = 1'b0;
    o_v0 = int'(valid);
    while (t < max_t && !(o_fin_t >= 0 && t > o_fin_t + 2)) begin
      if (valid) o_nvalid++;
      if (busy) o_nbusy++;
      if (opr_finished) begin o_nfin++; if (o_fin_t < 0) o_fin_t = t; end
      if (seq_err && o_err_t < 0) begin o_err_t = t; o_busy_err = int'(busy); end
      ph = t % 5;
      idx = (t + 4) / 5;
      if (t == inj_t) lines = inj_code;
      else if ((o_fin_t >= 0 && t > o_fin_t) || o_err_t >= 0) lines = code(0);
      else lines = code(ph);
      instr_is_halt = (ph == 1 && idx == halt_idx) ||
                      (noise && (ph == 2 || ph == 3) && $urandom_range(0, 1) == 1);
      start = (t == xstart_t);
      @(posedge clk); #1;
      t++;
    end
    start = 1'b0; instr_is_halt = 1'b0; lines = code(0);
  endtask

  task automatic test_reset();
    do_reset();
    ntot++; if ({valid, opr_finished, busy, instr_addr, instr_cnt, halted, seq_err} !== '0)
      $display("FAIL reset_outputs got v=%b f=%b b=%b a=%h c=%0d h=%b e=%b want all 0",
               valid, opr_finished, busy, instr_addr, instr_cnt, halted, seq_err);
    else npass++;
  endtask

  task automatic test_limit();
    drive(10'h010, 0, 1'b0, -1, 5'b0, -1, 5*MAX + 10);
    ntot++; if (o_v0 !== 1) $display("FAIL limit_valid_lat got %0d want 1", o_v0); else npass++;
    ntot++; if (o_fin_t + 1 !== 5*MAX) $display("FAIL limit_run_len got %0d want %0d", o_fin_t + 1, 5*MAX); else npass++;
    ntot++; if (o_nfin !== 1) $display("FAIL limit_nfin got %0d want 1", o_nfin); else npass++;
    ntot++; if (o_nvalid !== 1) $display("FAIL limit_nvalid got %0d want 1", o_nvalid); else npass++;
    ntot++; if (o_nbusy !== 5*MAX) $display("FAIL limit_busy_cycles got %0d want %0d", o_nbusy, 5*MAX); else npass++;
    ntot++; if (instr_cnt !== 9'(MAX)) $display("FAIL limit_cnt got %0d want %0d", instr_cnt, MAX); else npass++;
    ntot++; if (halted !== 1'b0) $display("FAIL limit_halted got %b want 0", halted); else npass++;
    ntot++; if (instr_addr !== 10'h19F) $display("FAIL limit_addr got %h want 19f", instr_addr); else npass++;
    ntot++; if (seq_err !== 1'b0) $display("FAIL limit_seq_err got %b want 0", seq_err); else npass++;
  endtask

  task automatic test_halt_wrap();
    drive(10'h3FE, 4, 1'b0, -1, 5'b0, -1, 100);
    ntot++; if (o_fin_t + 1 !== 20) $display("FAIL halt_run_len got %0d want 20", o_fin_t + 1); else npass++;
    ntot++; if (o_nfin !== 1) $display("FAIL halt_nfin got %0d want 1", o_nfin); else npass++;
    ntot++; if (instr_cnt !== 9'd4) $display("FAIL halt_cnt got %0d want 4", instr_cnt); else npass++;
    ntot++; if (halted !== 1'b1) $display("FAIL halt_halted got %b want 1", halted); else npass++;
    ntot++; if (instr_addr !== 10'h001) $display("FAIL halt_addr got %h want 001", instr_addr); else npass++;
  endtask

  task automatic test_halt_wrong_phase();
    drive(10'h123, 0, 1'b1, -1, 5'b0, -1, 5*MAX + 10);
    ntot++; if (o_fin_t + 1 !== 5*MAX) $display("FAIL noise_run_len got %0d want %0d", o_fin_t + 1, 5*MAX); else npass++;
    ntot++; if (instr_cnt !== 9'(MAX)) $display("FAIL noise_cnt got %0d want %0d", instr_cnt, MAX); else npass++;
    ntot++; if (halted !== 1'b0) $display("FAIL noise_halted got %b want 0", halted); else npass++;
  endtask

  task automatic test_halt_at_limit();
    drive(10'h200, MAX, 1'b0, -1, 5'b0, -1, 5*MAX + 10);
    ntot++; if (o_nfin !== 1) $display("FAIL hlim_nfin got %0d want 1", o_nfin); else npass++;
    ntot++; if (o_fin_t + 1 !== 5*MAX) $display("FAIL hlim_run_len got %0d want %0d", o_fin_t + 1, 5*MAX); else npass++;
    ntot++; if (halted !== 1'b1) $display("FAIL hlim_halted got %b want 1", halted); else npass++;
  endtask

  task automatic test_skip_phase();
    int nv;
    nv = 0;
    drive(10'h050, 0, 1'b0, 14, code(0), -1, 25);
    ntot++; if (o_err_t !== 15) $display("FAIL skip_err_cycle got %0d want 15", o_err_t); else npass++;
    ntot++; if (o_busy_err !== 0) $display("FAIL skip_busy got %0d want 0", o_busy_err); else npass++;
    ntot++; if (o_nfin !== 0) $display("FAIL skip_nfin got %0d want 0", o_nfin); else npass++;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    repeat (6) begin if (valid) nv++; @(posedge clk); #1; end
    ntot++; if (nv !== 0) $display("FAIL skip_restart_valid got %0d want 0", nv); else npass++;
    ntot++; if (seq_err !== 1'b1) $display("FAIL skip_sticky got %b want 1", seq_err); else npass++;
    do_reset();
    ntot++; if (seq_err !== 1'b0) $display("FAIL skip_reset_clear got %b want 0", seq_err); else npass++;
  endtask

  task automatic test_bad_code();
    drive(10'h0A0, 3, 1'b0, 7, 5'b00101, -1, 25);
    ntot++; if (o_err_t !== 8) $display("FAIL badcode_err_cycle got %0d want 8", o_err_t); else npass++;
    ntot++; if (o_nvalid !== 1) $display("FAIL badcode_nvalid got %0d want 1", o_nvalid); else npass++;
    ntot++; if (o_nfin !== 0) $display("FAIL badcode_nfin got %0d want 0", o_nfin); else npass++;
    do_reset();
  endtask

  task automatic test_reset_mid_run();
    drive(10'h300, 0, 1'b0, -1, 5'b0, 10, 37);
    ntot++; if (o_nvalid !== 1) $display("FAIL mid_extra_start got %0d valids want 1", o_nvalid); else npass++;
    ntot++; if (instr_cnt !== 9'd7) $display("FAIL mid_cnt got %0d want 7", instr_cnt); else npass++;
    ntot++; if (busy !== 1'b1) $display("FAIL mid_busy got %b want 1", busy); else npass++;
    rstb = 1'b1; lines = code(0);
    @(posedge clk); #1 rstb = 1'b0;
    ntot++; if ({valid, opr_finished, busy, instr_addr, instr_cnt, halted, seq_err} !== '0)
      $display("FAIL mid_reset_outputs got b=%b a=%h c=%0d want all 0", busy, instr_addr, instr_cnt);
    else npass++;
    drive(10'h3FF, 3, 1'b0, -1, 5'b0, -1, 100);
    ntot++; if (o_fin_t + 1 !== 15) $display("FAIL mid_rerun_len got %0d want 15", o_fin_t + 1); else npass++;
    ntot++; if (instr_cnt !== 9'd3) $display("FAIL mid_rerun_cnt got %0d want 3", instr_cnt); else npass++;
    ntot++; if (instr_addr !== 10'h001) $display("FAIL mid_rerun_addr got %h want 001", instr_addr); else npass++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      logic [AW-1:0] sa;
      int hi, n, eh;
      logic [AW-1:0] ea;
      sa = AW'($urandom);
      hi = $urandom_range(1, 30);
      n  = (hi >= 1 && hi <= MAX) ? hi : MAX;
      eh = (hi >= 1 && hi <= MAX) ? 1 : 0;
      ea = AW'((int'(sa) + n - 1) % (1 << AW));
      drive(sa, hi, 1'($urandom_range(0, 1)), -1, 5'b0, -1, 5*MAX + 10);
      ntot++; if (o_fin_t + 1 !== 5*n) $display("FAIL rnd%0d_run_len got %0d want %0d", r, o_fin_t + 1, 5*n); else npass++;
      ntot++; if (o_nfin !== 1) $display("FAIL rnd%0d_nfin got %0d want 1", r, o_nfin); else npass++;
      ntot++; if (instr_cnt !== 9'(n)) $display("FAIL rnd%0d_cnt got %0d want %0d", r, instr_cnt, n); else npass++;
      ntot++; if (int'(halted) !== eh) $display("FAIL rnd%0d_halted got %b want %0d", r, halted, eh); else npass++;
      ntot++; if (instr_addr !== ea) $display("FAIL rnd%0d_addr got %h want %h", r, instr_addr, ea); else npass++;
    end
  endtask

  initial begin
    test_reset();
    test_limit();
    test_halt_wrap();
    test_halt_wrong_phase();
    test_halt_at_limit();
    test_skip_phase();
    test_bad_code();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/opr_seq_resp.md
Name: opr_seq_resp

Overview:
- Responder side of the operation-pulse interface: issues the `valid` launch pulse to the operation controller and consumes its staggered stage-enable lines opr_1..opr_5.
- Decodes the 5-cycle instruction phase from those lines, checks the sequence and tracks the current instruction address.
- Terminates the run by returning `opr_finished` on a halt instruction or when the instruction limit is reached.
- Sits between the top-level start logic / instruction decode and the operation controller.

Parameters:
- MAX_INSTR, 400, instructions per run; legal range 1..409 so that MAX_INSTR*5 <= 2047, which keeps the controller's 11-bit counter from wrapping.
- AW, 10, instruction address width (1024-line memory image).

Ports:
- clk  in  1  clock
- rstb  in  1  reset, synchronous, active-high
- start  in  1  run request, single-cycle pulse
- start_addr  in  AW  first instruction address, sampled with start
- instr_is_halt  in  1  decoded halt flag for the current instruction; qualified only at phase 1
- opr_1..opr_5  in  1 each  stage enables from the operation controller
- valid  out  1  launch pulse to the controller
- opr_finished  out  1  run-complete pulse to the controller
- busy  out  1  high from the valid cycle through the opr_finished cycle
- instr_addr  out  AW  address of the instruction currently in flight
- instr_cnt  out  9  instructions fully sequenced in the current run
- halted  out  1  termination cause: 1 = halt instruction, 0 = limit; valid after finish
- seq_err  out  1  sticky protocol error

Behaviour:
- Reset (rstb=1 at a clk edge): state IDLE; all outputs 0; instr_addr 0; instr_cnt 0.
- Phase decode: phase = (number of asserted opr_k) - 1, range 0..4.
  - Lines must be a thermometer code: opr_1 always high, and opr_k implies opr_(k-1).
  - Any non-thermometer code while busy → seq_err.
- States: IDLE, LAUNCH, RUN, ERR.
- IDLE:
  - The controller idles at phase 0.
  - start=1 → LAUNCH next cycle; start_addr is latched into instr_addr; instr_cnt and halted are cleared.
  - start is ignored in every state other than IDLE.
- LAUNCH: exactly one cycle.
  - valid=1 and busy=1; phase 0 expected.
  - Next state RUN, with expected phase 1.
- RUN:
  - Each cycle the observed phase must equal the expected phase. Expected phase advances 1→2→3→4→0→1… (mod 5).
  - Phase 1: instr_is_halt is sampled into an internal end flag.
  - Phase 3: the final-instruction decision is registered. Final if (end flag) OR (instr_cnt == MAX_INSTR-1). When final, set halted = end flag.
  - Phase 4 of a non-final instruction: instr_cnt += 1 and instr_addr += 1 (mod 2^AW) at the end of the cycle.
  - Phase 4 of the final instruction:
    - opr_finished=1 for exactly this cycle, as a registered output.
    - instr_cnt += 1; instr_addr holds the final instruction's address.
    - Next state IDLE; busy drops the following cycle.
- Latency:
  - start → valid: 1 cycle.
  - valid → first phase 1: 1 cycle.
  - Each instruction occupies 5 cycles.
  - Run length in cycles from valid to opr_finished inclusive = 5*N, where N = instructions sequenced.
- Phase mismatch or illegal code in LAUNCH or RUN:
  - Go to ERR; seq_err=1; busy=0; valid=0; opr_finished=0.
  - ERR holds until reset. seq_err remains set until reset.
- Halt on the MAX_INSTR-th instruction: single finish; halted=1.
- Halt flag at any phase other than 1: ignored.
- Reset mid-run: immediate return to IDLE with all outputs 0. The system resets the controller in the same event.
- instr_addr wrap: start_addr + count wraps modulo 2^AW with no error.

Test Plan:
1. Reset, then start pulse with start_addr=0x010; a controller model answers valid. Required: valid high 1 cycle after start; opr_finished exactly 5*400 = 2000 cycles after valid; instr_cnt=400; halted=0; instr_addr=0x19F.
2. Start with start_addr=0x3FE; instr_is_halt=1 at phase 1 of the 4th instruction. Required: opr_finished at that instruction's phase 4, 20 cycles after valid; instr_cnt=4; halted=1; instr_addr=0x001.
3. Halt asserted at phase 2 or phase 3 only. Required: ignored; run continues to limit; halted=0.
4. Controller model skips a phase (3→0) mid-run. Required: seq_err=1 and busy=0 in the next cycle; opr_finished never asserted; a later start is ignored until reset.
5. Assert start while busy, and assert rstb mid-run at instr_cnt=7. Required: extra start ignored; after the reset edge all outputs are 0 and state is IDLE; a following start runs cleanly from instr_cnt=0.
6. Inject a non-thermometer code (opr_3=1 with opr_2=0) in RUN. Required: seq_err=1 the next cycle; valid and opr_finished both stay 0.
